// File: rtl/div_digit_select_stage_if.sv
// Handshake and datapath bundle between the parallel adder/driver side and
// the online-division digit-selection stage.
interface div_digit_select_stage_if #(
  parameter int bits = 64
);
  logic            start;
  logic            in_valid;
  logic            in_ready;
  logic [bits-1:0] sum_plus;
  logic [bits-1:0] sum_minus;
  logic            compare;
  logic [bits-1:0] residue_plus;
  logic [bits-1:0] residue_minus;
  logic            q_plus;
  logic            q_minus;
  logic            q_valid;
  logic            q_ready;
  logic            busy;
  logic            done;
  logic            rem_neg;

  // Driver side: supplies sums and consumes digits.
  modport master (
    output start, in_valid, sum_plus, sum_minus, compare, q_ready,
    input  in_ready, residue_plus, residue_minus, q_plus, q_minus,
           q_valid, busy, done, rem_neg
  );

  // Stage side: consumes sums and produces digits and residues.
  modport slave (
    input  start, in_valid, sum_plus, sum_minus, compare, q_ready,
    output in_ready, residue_plus, residue_minus, q_plus, q_minus,
           q_valid, busy, done, rem_neg
  );
endinterface

// File: rtl/div_digit_select_stage.sv
// Digit-selection stage of an online (MSD-first) divider. Each accepted
// redundant sum is reduced to a signed digit from a 4-bit top estimate,
// the residue is corrected and shifted, and the digit is handed off
// through a one-deep valid/ready register.
module div_digit_select_stage #(
  parameter int bits   = 64,
  parameter int DELTA  = 3,
  parameter int DIGITS = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  div_digit_select_stage_if.slave  bus
);

  // Counter widths never collapse to zero even for degenerate parameters.
  localparam int WCW = (DELTA  > 0) ? $clog2(DELTA + 1)  : 1;
  localparam int DCW = (DIGITS > 0) ? $clog2(DIGITS + 1) : 1;

  // Correction constant 1 << (bits-2), added to the opposite rail of the
  // selected digit so the residue stays bounded.
  localparam logic [bits-1:0] K = {2'b01, {(bits-2){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WARMUP = 3'd1,
    S_ITER   = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state_reg, state_next;
  logic [WCW-1:0]  warm_cnt_reg;
  logic [DCW-1:0]  dig_cnt_reg;
  logic [bits-1:0] residue_plus_reg, residue_minus_reg;
  logic            q_plus_reg, q_minus_reg, q_valid_reg, rem_neg_reg;

  logic            in_ready_int;
  logic            accept;
  logic            handoff;
  logic            start_ok;
  logic            warm_last;
  logic            dig_last;
  logic [4:0]      est;
  logic            sel_pos, sel_neg;
  logic [bits-1:0] sum_plus_adj, sum_minus_adj;

  // Handshake qualifiers. start is only honoured from IDLE or DONE.
  assign accept    = bus.in_valid && in_ready_int;
  assign handoff   = q_valid_reg && bus.q_ready;
  assign start_ok  = bus.start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
  assign warm_last = (int'(warm_cnt_reg) == DELTA - 1);
  assign dig_last  = (int'(dig_cnt_reg) == DIGITS - 1);

  // Signed estimate of the residue from the top four bits of each rail.
  assign est = {1'b0, bus.sum_plus[bits-1:bits-4]} - {1'b0, bus.sum_minus[bits-1:bits-4]};

  // Digit is forced to zero outside ITER (warm-up inputs emit nothing).
  // +1 when E >= 1; -1 when E <= -2 (negative but not -1).
  assign sel_pos = (state_reg == S_ITER) && !est[4] && (est != 5'd0);
  assign sel_neg = (state_reg == S_ITER) && est[4] && (est != 5'b11111);

  // Correction on the rail opposite the selected digit, before the shift.
  assign sum_plus_adj  = sel_neg ? (bus.sum_plus  + K) : bus.sum_plus;
  assign sum_minus_adj = sel_pos ? (bus.sum_minus + K) : bus.sum_minus;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.start) state_next = (DELTA == 0) ? S_ITER : S_WARMUP;
      end
      S_WARMUP: begin
        if (accept && warm_last) state_next = S_ITER;
      end
      S_ITER: begin
        if (accept && dig_last) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (handoff) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs; in_ready also waits for the digit slot to free.
  always_comb begin
    in_ready_int = ((state_reg == S_WARMUP) || (state_reg == S_ITER)) &&
                   (!q_valid_reg || bus.q_ready);
    bus.busy     = (state_reg == S_WARMUP) || (state_reg == S_ITER) ||
                   (state_reg == S_DRAIN);
    bus.done     = (state_reg == S_DONE);
  end

  assign bus.in_ready = in_ready_int;

  // Residue, counters, digit register and remainder sign.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      residue_plus_reg  <= '0;
      residue_minus_reg <= '0;
      warm_cnt_reg      <= '0;
      dig_cnt_reg       <= '0;
      q_plus_reg        <= 1'b0;
      q_minus_reg       <= 1'b0;
      q_valid_reg       <= 1'b0;
      rem_neg_reg       <= 1'b0;
    end else if (start_ok) begin
      residue_plus_reg  <= '0;
      residue_minus_reg <= '0;
      warm_cnt_reg      <= '0;
      dig_cnt_reg       <= '0;
      q_plus_reg        <= 1'b0;
      q_minus_reg       <= 1'b0;
      q_valid_reg       <= 1'b0;
      rem_neg_reg       <= 1'b0;
    end else if (accept) begin
      residue_plus_reg  <= {sum_plus_adj[bits-2:0], 1'b0};
      residue_minus_reg <= {sum_minus_adj[bits-2:0], 1'b0};
      if (state_reg == S_WARMUP) begin
        warm_cnt_reg <= warm_cnt_reg + WCW'(1);
      end else begin
        // A digit slot is free here (accept implies !q_valid || q_ready),
        // so a simultaneous handoff simply reloads with q_valid kept high.
        q_plus_reg  <= sel_pos;
        q_minus_reg <= sel_neg;
        q_valid_reg <= 1'b1;
        dig_cnt_reg <= dig_cnt_reg + DCW'(1);
        if (dig_last) rem_neg_reg <= bus.compare;
      end
    end else if (handoff) begin
      q_valid_reg <= 1'b0;
    end
  end

  assign bus.residue_plus  = residue_plus_reg;
  assign bus.residue_minus = residue_minus_reg;
  assign bus.q_plus        = q_plus_reg;
  assign bus.q_minus       = q_minus_reg;
  assign bus.q_valid       = q_valid_reg;
  assign bus.rem_neg       = rem_neg_reg;

endmodule

// File: tb/tb_div_digit_select_stage.sv
// Directed-vector bench for the digit-selection stage (bits=8, DELTA=2,
// DIGITS=4). Inputs change 1 time unit after the rising edge and outputs
// are checked at that point, after the edge has settled.
module tb_div_digit_select_stage;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  div_digit_select_stage_if #(.bits(8)) bus ();

  div_digit_select_stage #(
    .bits   (8),
    .DELTA  (2),
    .DIGITS (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    vectors++;
    if ({bus.residue_plus, bus.residue_minus, bus.q_plus, bus.q_minus, bus.q_valid,
         bus.in_ready, bus.busy, bus.done, bus.rem_neg} !== 23'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rp=%h rm=%h qv=%b rdy=%b busy=%b done=%b, want all 0",
               bus.residue_plus, bus.residue_minus, bus.q_valid, bus.in_ready, bus.busy, bus.done);
    end
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    step();
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_ready: got in_ready=%b busy=%b, want 0 0", bus.in_ready, bus.busy);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_warmup();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++;
    if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_warmup: got busy=%b rdy=%b done=%b, want 1 1 0", bus.busy, bus.in_ready, bus.done);
    end
    bus.in_valid = 1'b1; bus.sum_plus = 8'h05; bus.sum_minus = 8'h00;
    step();
    vectors++;
    if (bus.residue_plus !== 8'h0A || bus.residue_minus !== 8'h00 || bus.q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL warmup1: got rp=%h rm=%h qv=%b, want 0a 00 0", bus.residue_plus, bus.residue_minus, bus.q_valid);
    end
    // E = 3 would select +1 in ITER; warm-up must still force q = 0.
    bus.sum_plus = 8'h30; bus.sum_minus = 8'h00;
    step();
    vectors++;
    if (bus.residue_plus !== 8'h60 || bus.residue_minus !== 8'h00 || bus.q_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL warmup2: got rp=%h rm=%h qv=%b, want 60 00 0", bus.residue_plus, bus.residue_minus, bus.q_valid);
    end
  endtask

  task automatic test_digit_plus();
    bus.q_ready = 1'b1;
    bus.sum_plus = 8'h30; bus.sum_minus = 8'h00;
    step();
    vectors++;
    if ({bus.q_plus, bus.q_minus, bus.q_valid} !== 3'b101 ||
        bus.residue_plus !== 8'h60 || bus.residue_minus !== 8'h80) begin
      miscompares++;
      $display("FAIL digit_plus: got q=%b%b qv=%b rp=%h rm=%h, want 10 1 60 80",
               bus.q_plus, bus.q_minus, bus.q_valid, bus.residue_plus, bus.residue_minus);
    end
  endtask

  task automatic test_digit_minus_zero();
    // Handoff of the previous digit and a new acceptance in the same cycle.
    bus.sum_plus = 8'h00; bus.sum_minus = 8'h20;
    step();
    vectors++;
    if ({bus.q_plus, bus.q_minus, bus.q_valid} !== 3'b011 ||
        bus.residue_plus !== 8'h80 || bus.residue_minus !== 8'h40) begin
      miscompares++;
      $display("FAIL digit_minus: got q=%b%b qv=%b rp=%h rm=%h, want 01 1 80 40",
               bus.q_plus, bus.q_minus, bus.q_valid, bus.residue_plus, bus.residue_minus);
    end
    bus.sum_plus = 8'h10; bus.sum_minus = 8'h20;
    step();
    vectors++;
    if ({bus.q_plus, bus.q_minus, bus.q_valid} !== 3'b001 ||
        bus.residue_plus !== 8'h20 || bus.residue_minus !== 8'h40) begin
      miscompares++;
      $display("FAIL digit_zero: got q=%b%b qv=%b rp=%h rm=%h, want 00 1 20 40",
               bus.q_plus, bus.q_minus, bus.q_valid, bus.residue_plus, bus.residue_minus);
    end
  endtask

  task automatic test_backpressure();
    bus.q_ready = 1'b0;
    bus.sum_plus = 8'h30; bus.sum_minus = 8'h00; bus.compare = 1'b1;
    bus.start = 1'b1;  // must be ignored mid-division
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({bus.q_plus, bus.q_minus, bus.q_valid, bus.in_ready, bus.busy} !== 5'b00101 ||
          bus.residue_plus !== 8'h20 || bus.residue_minus !== 8'h40) begin
        miscompares++;
        $display("FAIL hold_%0d: got q=%b%b qv=%b rdy=%b busy=%b rp=%h rm=%h, want 00 1 0 1 20 40", i,
                 bus.q_plus, bus.q_minus, bus.q_valid, bus.in_ready, bus.busy, bus.residue_plus, bus.residue_minus);
      end
    end
    bus.start = 1'b0;
    bus.q_ready = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_on_qready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_completion();
    // 4th digit: accepted together with the pending handoff.
    step();
    vectors++;
    if ({bus.q_plus, bus.q_minus, bus.q_valid, bus.in_ready, bus.busy, bus.done, bus.rem_neg} !== 7'b1010101 ||
        bus.residue_plus !== 8'h60 || bus.residue_minus !== 8'h80) begin
      miscompares++;
      $display("FAIL last_digit: got q=%b%b qv=%b rdy=%b busy=%b done=%b rn=%b rp=%h rm=%h, want 10 1 0 1 0 1 60 80",
               bus.q_plus, bus.q_minus, bus.q_valid, bus.in_ready, bus.busy, bus.done, bus.rem_neg,
               bus.residue_plus, bus.residue_minus);
    end
    // DRAIN holds while the digit is not taken; inputs ignored.
    bus.q_ready = 1'b0;
    bus.sum_plus = 8'h11; bus.sum_minus = 8'h22;
    step();
    vectors++;
    if ({bus.q_valid, bus.in_ready, bus.busy, bus.done} !== 4'b1010 || bus.residue_plus !== 8'h60) begin
      miscompares++;
      $display("FAIL drain_hold: got qv=%b rdy=%b busy=%b done=%b rp=%h, want 1 0 1 0 60",
               bus.q_valid, bus.in_ready, bus.busy, bus.done, bus.residue_plus);
    end
    bus.q_ready = 1'b1;
    step();
    vectors++;
    if ({bus.q_valid, bus.busy, bus.done, bus.rem_neg} !== 4'b0011) begin
      miscompares++;
      $display("FAIL done: got qv=%b busy=%b done=%b rn=%b, want 0 0 1 1",
               bus.q_valid, bus.busy, bus.done, bus.rem_neg);
    end
    step();
    vectors++;
    if (bus.done !== 1'b1 || bus.residue_minus !== 8'h80) begin
      miscompares++;
      $display("FAIL done_held: got done=%b rm=%h, want 1 80", bus.done, bus.residue_minus);
    end
  endtask

  task automatic test_restart();
    bus.in_valid = 1'b0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    vectors++;
    if (bus.residue_plus !== 8'h00 || bus.residue_minus !== 8'h00 ||
        {bus.busy, bus.done, bus.rem_neg, bus.q_plus, bus.q_valid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL restart: got rp=%h rm=%h busy=%b done=%b rn=%b qp=%b qv=%b, want 00 00 1 0 0 0 0",
               bus.residue_plus, bus.residue_minus, bus.busy, bus.done, bus.rem_neg, bus.q_plus, bus.q_valid);
    end
  endtask

  task automatic test_reset_mid();
    bus.in_valid = 1'b1; bus.sum_plus = 8'h01; bus.sum_minus = 8'h00;
    step();
    step();
    bus.q_ready = 1'b0;
    bus.sum_plus = 8'h00; bus.sum_minus = 8'h30;  // E = -3 -> q = -1
    step();
    vectors++;
    if ({bus.q_minus, bus.q_valid} !== 2'b11) begin
      miscompares++;
      $display("FAIL pre_reset_digit: got qm=%b qv=%b, want 1 1", bus.q_minus, bus.q_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.residue_plus, bus.residue_minus, bus.q_plus, bus.q_minus, bus.q_valid,
         bus.in_ready, bus.busy, bus.done, bus.rem_neg} !== 23'd0) begin
      miscompares++;
      $display("FAIL async_reset: got rp=%h rm=%h qm=%b qv=%b rdy=%b busy=%b, want all 0",
               bus.residue_plus, bus.residue_minus, bus.q_minus, bus.q_valid, bus.in_ready, bus.busy);
    end
    step();
    rst_n = 1'b1;
    bus.q_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({bus.in_ready, bus.q_valid, bus.busy, bus.residue_plus} !== 11'd0) begin
        miscompares++;
        $display("FAIL post_reset_%0d: got rdy=%b qv=%b busy=%b rp=%h, want 0 0 0 00",
                 i, bus.in_ready, bus.q_valid, bus.busy, bus.residue_plus);
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.sum_plus  = 8'h00;
    bus.sum_minus = 8'h00;
    bus.compare   = 1'b0;
    bus.q_ready   = 1'b0;
    step();
    test_reset();
    test_warmup();
    test_digit_plus();
    test_digit_minus_zero();
    test_backpressure();
    test_completion();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
